// File: rtl/map_sst_master_pkg.sv
// Shared types and constants for the mapper save-state initiator.
package map_sst_master_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACT,
    ST_SV_ADDR,
    ST_SV_MEM,
    ST_LD_HDR,
    ST_LD_RD,
    ST_LD_WR,
    ST_FIN,
    ST_FAIL
  } sst_state_e;

  localparam logic [7:0]  SST_HDR_IDX   = 8'd127;
  localparam int unsigned M2_SYNC_DEPTH = 2;

endpackage

// File: rtl/map_sst_master_m2_edge_det.sv
// Brings CPU M2 into the clk domain and emits a one-cycle pulse per falling edge.
module m2_edge_det
  import map_sst_master_pkg::*;
#(
  parameter int unsigned DEPTH = M2_SYNC_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic m2,
  output logic m2_fall
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;
  logic             prev_q;
  logic             prev_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], m2};
    prev_d = sync_q[DEPTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign m2_fall = prev_q & ~sync_q[DEPTH-1];

endmodule

// File: rtl/map_sst_master.sv
// Save-state bus initiator: snapshots mapper registers to a buffer and restores them.
module map_sst_master
  import map_sst_master_pkg::*;
#(
  parameter int unsigned REG_CNT = int'(SST_HDR_IDX) + 1,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned M2_TO   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] map_idx,
  input  logic       m2,
  output logic       sst_act,
  output logic [7:0] sst_addr,
  output logic       sst_we_reg,
  output logic [7:0] sst_dato,
  input  logic [7:0] sst_di,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_do,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_di,
  input  logic       mem_ack,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CNT_MAX = (M2_TO > SETTLE) ? M2_TO : SETTLE;
  localparam int unsigned CW      = $clog2(CNT_MAX + 2);
  localparam logic [7:0]  HDR_IDX = 8'(REG_CNT - 1);
  localparam int unsigned ACT_WAIT = 2;

  sst_state_e    state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          falls_q, falls_d;
  logic          mode_q, mode_d;
  logic          act_q, act_d;
  logic [7:0]    addr_q, addr_d;
  logic          we_reg_q, we_reg_d;
  logic [7:0]    dato_q, dato_d;
  logic [7:0]    mem_addr_q, mem_addr_d;
  logic [7:0]    mem_do_q, mem_do_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_re_q, mem_re_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          m2_fall;

  m2_edge_det #(.DEPTH(M2_SYNC_DEPTH)) u_m2_edge (
    .clk     (clk),
    .rst     (rst),
    .m2      (m2),
    .m2_fall (m2_fall)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    falls_d    = falls_q;
    mode_d     = mode_q;
    act_d      = act_q;
    addr_d     = addr_q;
    we_reg_d   = we_reg_q;
    dato_d     = dato_q;
    mem_addr_d = mem_addr_q;
    mem_do_d   = mem_do_q;
    mem_we_d   = mem_we_q;
    mem_re_d   = mem_re_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          err_d   = 1'b0;
          act_d   = 1'b1;
          mode_d  = mode;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACT;
        end
      end

      ST_ACT: begin
        if (cnt_q == CW'(ACT_WAIT - 1)) begin
          cnt_d = '0;
          if (mode_q) begin
            mem_addr_d = HDR_IDX;
            mem_re_d   = 1'b1;
            state_d    = ST_LD_HDR;
          end else begin
            addr_d  = idx_q;
            state_d = ST_SV_ADDR;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_SV_ADDR: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          mem_do_d   = sst_di;
          mem_addr_d = idx_q;
          mem_we_d   = 1'b1;
          state_d    = ST_SV_MEM;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_SV_MEM: begin
        if (mem_we_q && mem_ack) begin
          mem_we_d = 1'b0;
          if (idx_q == HDR_IDX) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + 8'd1;
            addr_d  = idx_q + 8'd1;
            cnt_d   = '0;
            state_d = ST_SV_ADDR;
          end
        end
      end

      ST_LD_HDR: begin
        if (mem_re_q && mem_ack) begin
          mem_re_d = 1'b0;
          if (mem_di != map_idx) begin
            state_d = ST_FAIL;
          end else begin
            idx_d   = '0;
            state_d = ST_LD_RD;
          end
        end
      end

      // Request is raised one cycle after entry so the buffer always sees an idle gap.
      ST_LD_RD: begin
        if (!mem_re_q) begin
          mem_re_d   = 1'b1;
          mem_addr_d = idx_q;
        end else if (mem_ack) begin
          mem_re_d = 1'b0;
          dato_d   = mem_di;
          addr_d   = idx_q;
          cnt_d    = '0;
          falls_d  = 1'b0;
          state_d  = ST_LD_WR;
        end
      end

      // Strobe rises a cycle after addr/data settle and is held across two M2 falls.
      ST_LD_WR: begin
        if (!we_reg_q) begin
          we_reg_d = 1'b1;
          cnt_d    = '0;
          falls_d  = 1'b0;
        end else if (m2_fall) begin
          cnt_d = '0;
          if (falls_q) begin
            we_reg_d = 1'b0;
            if (idx_q == HDR_IDX - 8'd1) begin
              state_d = ST_FIN;
            end else begin
              idx_d   = idx_q + 8'd1;
              state_d = ST_LD_RD;
            end
          end else begin
            falls_d = 1'b1;
          end
        end else if (cnt_q == CW'(M2_TO - 1)) begin
          state_d = ST_FAIL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_FIN: begin
        act_d   = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      ST_FAIL: begin
        we_reg_d = 1'b0;
        act_d    = 1'b0;
        mem_we_d = 1'b0;
        mem_re_d = 1'b0;
        err_d    = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      falls_q    <= 1'b0;
      mode_q     <= 1'b0;
      act_q      <= 1'b0;
      addr_q     <= '0;
      we_reg_q   <= 1'b0;
      dato_q     <= '0;
      mem_addr_q <= '0;
      mem_do_q   <= '0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      falls_q    <= falls_d;
      mode_q     <= mode_d;
      act_q      <= act_d;
      addr_q     <= addr_d;
      we_reg_q   <= we_reg_d;
      dato_q     <= dato_d;
      mem_addr_q <= mem_addr_d;
      mem_do_q   <= mem_do_d;
      mem_we_q   <= mem_we_d;
      mem_re_q   <= mem_re_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign sst_act    = act_q;
  assign sst_addr   = addr_q;
  assign sst_we_reg = we_reg_q;
  assign sst_dato   = dato_q;
  assign mem_addr   = mem_addr_q;
  assign mem_do     = mem_do_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_map_sst_master.sv
// Directed bench for map_sst_master with buffer, mapper responder and M2 models.
module tb_map_sst_master;

  localparam int M2_TO = 4096;

  logic       clk = 1'b0;
  logic       rst, start, mode, m2;
  logic [7:0] map_idx, sst_di, mem_di;
  logic       mem_ack;
  logic       sst_act, sst_we_reg, mem_we, mem_re, busy, done, err;
  logic [7:0] sst_addr, sst_dato, mem_addr, mem_do;

  int checks = 0;
  int errors = 0;

  logic [7:0] bufm [0:255];
  logic [7:0] regw [0:127];
  bit         regw_seen [0:127];
  int mem_wr_cnt, mem_rd_cnt, order_bad, proto_viol, we_rise, done_cnt, first_we_addr;
  bit rand_lat, stray_en, m2_en;
  int resp_mode;

  always #5 clk = ~clk;

  map_sst_master #(.REG_CNT(128), .SETTLE(2), .M2_TO(M2_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .map_idx(map_idx), .m2(m2),
    .sst_act(sst_act), .sst_addr(sst_addr), .sst_we_reg(sst_we_reg), .sst_dato(sst_dato),
    .sst_di(sst_di), .mem_addr(mem_addr), .mem_do(mem_do), .mem_we(mem_we), .mem_re(mem_re),
    .mem_di(mem_di), .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
  );

  // Mapper readback responder.
  always_comb begin
    sst_di = 8'hFF;
    if (sst_addr == 8'd127) sst_di = map_idx;
    else if (resp_mode == 0) sst_di = (sst_addr == 8'd0) ? 8'h13 : 8'hFF;
    else sst_di = sst_addr ^ 8'hA5;
  end

  // Mapper register latch on M2 fall.
  initial begin
    forever begin
      @(negedge m2);
      if (sst_act && sst_we_reg && sst_addr < 8'd128) begin
        regw[sst_addr[6:0]] = sst_dato;
        regw_seen[sst_addr[6:0]] = 1'b1;
      end
    end
  end

  // CPU M2 at roughly 1.79 MHz against a 100 MHz clk; disabling holds it low.
  initial begin
    m2 = 1'b0;
    forever begin
      if (m2_en) begin
        m2 = 1'b1; #280;
        m2 = 1'b0; #280;
      end else begin
        #10;
      end
    end
  end

  // Snapshot buffer with handshake protocol checking.
  initial begin
    int lat;
    logic [7:0] a, d;
    logic w;
    mem_ack = 1'b0;
    mem_di = 8'h00;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_we || mem_re) begin
        if (mem_we && mem_re) proto_viol++;
        lat = rand_lat ? int'($urandom_range(1, 20)) : 1;
        a = mem_addr; d = mem_do; w = mem_we;
        for (int k = 1; k < lat; k++) begin
          @(posedge clk); #1;
          if ((mem_we !== w) || (mem_re !== !w) || (mem_addr !== a) || (w && mem_do !== d))
            proto_viol++;
        end
        mem_ack = 1'b1;
        if (w) begin
          if (a !== 8'(mem_wr_cnt)) order_bad++;
          bufm[a] = d;
          mem_wr_cnt++;
        end else begin
          mem_di = bufm[a];
          mem_rd_cnt++;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (mem_we || mem_re) proto_viol++;
      end else if (stray_en && $urandom_range(0, 3) == 0) begin
        mem_ack = 1'b1;
        mem_di = 8'hEE;
      end
    end
  end

  // Strobe stability, strobe count and done pulses.
  initial begin
    logic pw;
    logic [7:0] pa, pd;
    pw = 1'b0; pa = 8'h00; pd = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (sst_we_reg && !pw) begin
        if (we_rise == 0) first_we_addr = int'(sst_addr);
        we_rise++;
      end
      if ((sst_we_reg || pw) && (sst_addr !== pa || sst_dato !== pd)) proto_viol++;
      if (done) done_cnt++;
      pw = sst_we_reg; pa = sst_addr; pd = sst_dato;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    mem_wr_cnt = 0; mem_rd_cnt = 0; order_bad = 0; proto_viol = 0;
    we_rise = 0; done_cnt = 0; first_we_addr = -1;
    for (int i = 0; i < 128; i++) begin
      regw[i] = 8'h00;
      regw_seen[i] = 1'b0;
    end
  endtask

  task automatic fill_load_buf(input logic [7:0] hdr);
    for (int i = 1; i < 127; i++) bufm[i] = 8'(i) ^ 8'h3C;
    bufm[0] = 8'h15;
    bufm[127] = hdr;
  endtask

  task automatic pulse_start(input logic m);
    @(negedge clk);
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sst_act, sst_we_reg, mem_we, mem_re, busy, done, err} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000000", {sst_act, sst_we_reg, mem_we, mem_re, busy, done, err});
    end
    checks++;
    if ({sst_addr, sst_dato, mem_addr, mem_do} !== 32'h0) begin
      errors++; $display("FAIL reset_data got %h exp 00000000", {sst_addr, sst_dato, mem_addr, mem_do});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, sst_act, mem_we, mem_re} !== 4'b0) begin
      errors++; $display("FAIL reset_idle got %b exp 0000", {busy, sst_act, mem_we, mem_re});
    end
  endtask

  task automatic test_save();
    int bad;
    clear_logs();
    resp_mode = 0; rand_lat = 1'b0;
    for (int i = 0; i < 256; i++) bufm[i] = 8'h00;
    pulse_start(1'b0);
    wait_idle(5000);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL save_timeout got busy %b exp 0", busy); end
    checks++;
    if (bufm[0] !== 8'h13) begin errors++; $display("FAIL save_buf0 got %h exp 13", bufm[0]); end
    checks++;
    if (bufm[127] !== 8'h07) begin errors++; $display("FAIL save_buf127 got %h exp 07", bufm[127]); end
    bad = 0;
    for (int i = 1; i < 127; i++) if (bufm[i] !== 8'hFF) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL save_body got %0d bad exp 0", bad); end
    checks++;
    if (mem_wr_cnt !== 128) begin errors++; $display("FAIL save_wr_cnt got %0d exp 128", mem_wr_cnt); end
    checks++;
    if (order_bad !== 0) begin errors++; $display("FAIL save_order got %0d exp 0", order_bad); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL save_done got %0d exp 1", done_cnt); end
    checks++;
    if ({err, sst_act, done} !== 3'b0) begin errors++; $display("FAIL save_flags got %b exp 000", {err, sst_act, done}); end
    checks++;
    if (we_rise !== 0 || proto_viol !== 0) begin
      errors++; $display("FAIL save_proto got we %0d viol %0d exp 0 0", we_rise, proto_viol);
    end
  endtask

  task automatic test_back_to_back();
    int bad, n;
    clear_logs();
    resp_mode = 1; rand_lat = 1'b1;
    for (int i = 0; i < 256; i++) bufm[i] = 8'h00;
    pulse_start(1'b0);
    n = 0;
    while (mem_wr_cnt < 40 && n < 5000) begin @(posedge clk); #1; n++; end
    checks++;
    if (mem_wr_cnt < 40) begin errors++; $display("FAIL b2b_progress got %0d exp 40", mem_wr_cnt); end
    pulse_start(1'b1);
    checks++;
    if (busy !== 1'b1 || mem_re !== 1'b0) begin
      errors++; $display("FAIL b2b_ignored got busy %b re %b exp 1 0", busy, mem_re);
    end
    wait_idle(20000);
    rand_lat = 1'b0;
    checks++;
    if (busy !== 1'b0 || done_cnt !== 1) begin
      errors++; $display("FAIL b2b_done got busy %b done %0d exp 0 1", busy, done_cnt);
    end
    checks++;
    if (mem_wr_cnt !== 128 || mem_rd_cnt !== 0 || order_bad !== 0) begin
      errors++; $display("FAIL b2b_traffic got wr %0d rd %0d ord %0d exp 128 0 0", mem_wr_cnt, mem_rd_cnt, order_bad);
    end
    bad = 0;
    for (int i = 0; i < 127; i++) if (bufm[i] !== (8'(i) ^ 8'hA5)) bad++;
    if (bufm[127] !== 8'h07) bad++;
    checks++;
    if (bad !== 0 || proto_viol !== 0 || err !== 1'b0) begin
      errors++; $display("FAIL b2b_data got bad %0d viol %0d err %b exp 0 0 0", bad, proto_viol, err);
    end
  endtask

  task automatic test_load();
    int bad;
    logic [7:0] r0;
    clear_logs();
    fill_load_buf(8'h07);
    map_idx = 8'h07; m2_en = 1'b1; stray_en = 1'b1;
    pulse_start(1'b1);
    wait_idle(30000);
    stray_en = 1'b0;
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || done_cnt !== 1) begin
      errors++; $display("FAIL load_end got busy %b err %b done %0d exp 0 0 1", busy, err, done_cnt);
    end
    r0 = regw[0];
    checks++;
    if (!regw_seen[0] || r0 !== 8'h15) begin errors++; $display("FAIL load_reg0 got %h exp 15", r0); end
    checks++;
    if (r0[3:0] !== 4'h5 || r0[4] !== 1'b1) begin
      errors++; $display("FAIL load_decode got prg %h vram %b exp 5 1", r0[3:0], r0[4]);
    end
    checks++;
    if (regw_seen[127] !== 1'b0) begin errors++; $display("FAIL load_hdr_write got %b exp 0", regw_seen[127]); end
    checks++;
    if (we_rise !== 127 || first_we_addr !== 0) begin
      errors++; $display("FAIL load_strobes got %0d first %0d exp 127 0", we_rise, first_we_addr);
    end
    bad = 0;
    for (int i = 1; i < 127; i++) if (!regw_seen[i] || regw[i] !== (8'(i) ^ 8'h3C)) bad++;
    checks++;
    if (bad !== 0 || proto_viol !== 0 || sst_act !== 1'b0) begin
      errors++; $display("FAIL load_body got bad %0d viol %0d act %b exp 0 0 0", bad, proto_viol, sst_act);
    end
  endtask

  task automatic test_hdr_mismatch();
    clear_logs();
    fill_load_buf(8'h22);
    map_idx = 8'h07;
    pulse_start(1'b1);
    wait_idle(500);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || sst_act !== 1'b0) begin
      errors++; $display("FAIL hdr_flags got err %b busy %b act %b exp 1 0 0", err, busy, sst_act);
    end
    checks++;
    if (we_rise !== 0 || done_cnt !== 0 || mem_rd_cnt !== 1) begin
      errors++; $display("FAIL hdr_activity got we %0d done %0d rd %0d exp 0 0 1", we_rise, done_cnt, mem_rd_cnt);
    end
  endtask

  task automatic test_m2_timeout();
    int n;
    clear_logs();
    fill_load_buf(8'h07);
    m2_en = 1'b1;
    pulse_start(1'b1);
    n = 0;
    while (!(sst_we_reg && sst_addr == 8'd3) && n < 3000) begin @(posedge clk); #1; n++; end
    checks++;
    if (!(sst_we_reg && sst_addr == 8'd3)) begin
      errors++; $display("FAIL to_reach got addr %0d we %b exp 3 1", sst_addr, sst_we_reg);
    end
    m2_en = 1'b0;
    n = 0;
    while (!err && n < M2_TO + 500) begin @(posedge clk); #1; n++; end
    checks++;
    if (err !== 1'b1 || n < M2_TO || n > M2_TO + 100) begin
      errors++; $display("FAIL to_latency got err %b cycles %0d exp 1 %0d..%0d", err, n, M2_TO, M2_TO + 100);
    end
    checks++;
    if ({sst_act, busy, sst_we_reg} !== 3'b0 || done_cnt !== 0) begin
      errors++; $display("FAIL to_flags got %b done %0d exp 000 0", {sst_act, busy, sst_we_reg}, done_cnt);
    end
    checks++;
    if (regw_seen[2] !== 1'b1 || regw_seen[5] !== 1'b0) begin
      errors++; $display("FAIL to_progress got seen2 %b seen5 %b exp 1 0", regw_seen[2], regw_seen[5]);
    end
  endtask

  task automatic test_reset_mid_load();
    int n, bad;
    clear_logs();
    fill_load_buf(8'h07);
    m2_en = 1'b1;
    pulse_start(1'b1);
    n = 0;
    while (!(sst_we_reg && sst_addr == 8'd2) && n < 3000) begin @(posedge clk); #1; n++; end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({sst_we_reg, sst_act, busy} !== 3'b0) begin
      errors++; $display("FAIL rst_async got %b exp 000", {sst_we_reg, sst_act, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
    pulse_start(1'b1);
    wait_idle(30000);
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || done_cnt !== 1) begin
      errors++; $display("FAIL rst_rerun got busy %b err %b done %0d exp 0 0 1", busy, err, done_cnt);
    end
    bad = 0;
    for (int i = 0; i < 127; i++) if (!regw_seen[i] || regw[i] !== bufm[i]) bad++;
    checks++;
    if (first_we_addr !== 0 || we_rise !== 127 || bad !== 0 || regw_seen[127] !== 1'b0) begin
      errors++; $display("FAIL rst_restore got first %0d we %0d bad %0d exp 0 127 0", first_we_addr, we_rise, bad);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; map_idx = 8'h07;
    m2_en = 1'b0; rand_lat = 1'b0; stray_en = 1'b0; resp_mode = 0;
    clear_logs();
    test_reset();
    test_save();
    test_back_to_back();
    test_load();
    test_hdr_mismatch();
    test_m2_timeout();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/map_sst_master.md
Name: map_sst_master

Overview:
- Save-state initiator for the mapper save-state bus. It is the controller side of the sst register interface that every mapper exposes as a responder.
- Save: walks the register index space, samples the mapper readback byte and stores it to an external snapshot buffer.
- Load: checks the stored mapper-index header byte, then writes the stored bytes back into the mapper registers.
- Mapper registers latch only on the falling edge of CPU M2 while act is high, so every write is held across a detected M2 fall.

Parameters:
- REG_CNT, 128: register indices walked, 0..REG_CNT-1. Index REG_CNT-1 is the read-only map_idx header.
- SETTLE, 2: clk cycles between an sst_addr change and sampling sst_di.
- M2_TO, 4096: clk cycles allowed while waiting for an M2 fall before aborting.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle request; ignored unless idle
- mode  in  1  0 = save, 1 = load
- map_idx  in  8  currently configured mapper index
- m2  in  1  CPU M2, asynchronous to clk
- sst_act  out  1  save-state bus ownership
- sst_addr  out  8  register index
- sst_we_reg  out  1  register write strobe (level)
- sst_dato  out  8  write data to mapper
- sst_di  in  8  readback data from mapper
- mem_addr  out  8  snapshot buffer address (= register index)
- mem_do  out  8  snapshot write data
- mem_we  out  1  buffer write request
- mem_re  out  1  buffer read request
- mem_di  in  8  buffer read data, valid with mem_ack
- mem_ack  in  1  buffer completion, one cycle
- busy  out  1  high from accepted start until done/err
- done  out  1  one-cycle pulse on success
- err  out  1  sticky fault flag, cleared by the next accepted start

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; index counter 0; M2 synchroniser cleared.
- M2 handling: two-flop synchroniser plus a previous-value register. m2_fall = prev & !sync.
- Buffer handshake: mem_we/mem_re are held with stable mem_addr/mem_do until mem_ack, then dropped the next cycle. The buffer never sees back-to-back requests without one idle cycle.
- Walk order: indices are walked in ascending order with an 8-bit counter and no wrap. The walk ends when the counter equals REG_CNT-1 at a step.

FSM states and transitions:
- IDLE → ACT on start: busy = 1, err = 0, sst_act = 1.
- ACT: wait 2 clk, then go to SV_ADDR (mode 0) or LD_HDR (mode 1).
- SV_ADDR: drive sst_addr = idx, count SETTLE cycles, then latch sst_di into mem_do and go to SV_MEM.
- SV_MEM: mem_we until ack. If idx == REG_CNT-1, go to FIN; otherwise idx++ and go to SV_ADDR.
- LD_HDR: mem_re at address REG_CNT-1.
  - On ack with mem_di != map_idx: go to FAIL. No register write occurs.
  - On match: idx = 0, go to LD_RD.
- LD_RD: mem_re at idx. On ack, latch into sst_dato, set sst_addr = idx, go to LD_WR.
- LD_WR: assert sst_we_reg and count M2 falls.
  - After the second m2_fall, drop sst_we_reg. The first fall may be partial; the second guarantees one full M2 low edge with stable addr/data.
  - Then go to LD_RD with idx++, or to FIN after idx == REG_CNT-2. The header index is never written.
- FIN: sst_act = 0, pulse done, busy = 0, go to IDLE.
- FAIL: drop sst_we_reg and sst_act, set err, busy = 0, go to IDLE.

Timeout:
- The M2 timeout counter runs only in LD_WR and is reset at each m2_fall.
- Reaching M2_TO goes to FAIL. This covers a stopped CPU clock.

Boundaries:
- start while busy is ignored.
- sst_we_reg is never high in the same cycle that sst_addr or sst_dato changes.
- Async reset mid-load drops sst_act and sst_we_reg immediately. A partial restore is accepted; software restarts the load.
- mem_ack outside a request is ignored.

Decomposition:
- Shared package holds: the FSM state enum, the SST_HDR_IDX constant (127) and the M2 synchroniser depth constant.
- One sub-module, m2_edge_det: synchroniser plus fall pulse, reused by other M2-domain helpers.

Test Plan:
- Save with a responder model (index 0 returns 0x13, index 127 returns map_idx 0x07, others 0xFF) → buffer holds 0x13 / 0xFF... / 0x07; exactly 128 mem_we; one done pulse; err = 0.
- Load with buffer[127] = 0x07, map_idx = 0x07, buffer[0] = 0x15, M2 at 1.79 MHz-equivalent → model sees one write at index 0 with data 0x15 (prg_bank = 5, vram_bit = 1); no write at index 127; done.
- Load with buffer[127] = 0x22, map_idx = 0x07 → zero sst_we_reg assertions; err = 1; done never pulses.
- Load with M2 held low after index 3 → err after M2_TO cycles; sst_act = 0; busy = 0.
- Buffer with random mem_ack latency 1..20 plus a start pulse mid-operation → second start ignored; order and data intact.
- rst asserted during LD_WR → sst_we_reg and sst_act low asynchronously; the next start runs cleanly from index 0.
